mem_arbiter: RTL

//  Shares the single off-chip data memory port between the instruction-cache (ic_*) and data-cache (dc_*) refill/write-back paths.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// No logic or latency of its own; state encoding, port indices and one-hot grant codes.
// No backpressure: pure declarations, imported by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IC   = 2'b01;
    localparam logic [1:0] GNT_DC   = 2'b10;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DC) ? GNT_DC : GNT_IC;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between icache and dcache requests; MEM_ARB_RR_EN gives round-robin ties, else DC wins.
// Combinational, zero latency.
// No backpressure: win is only meaningful while at least one request is high.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_grant,
    output logic win
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        win = PORT_IC;
        if (ic_req && dc_req) begin
`ifdef MEM_ARB_RR_EN
            win = (last_grant == PORT_DC) ? PORT_IC : PORT_DC;
`else
            win = PORT_DC;
`endif
        end else if (dc_req) begin
            win = PORT_DC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache line transactions onto one memory port (MEM_ARB_RR_EN selects round-robin ties).
// Latency: req to mem_enable_o 1 cycle, mem_ack_i to *_ack_o 1 cycle, 3 cycles minimum end to end.
// Backpressure: requesters hold req until their one-cycle ack; a losing request waits for the next IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_i,
    input  logic              ic_write_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic [LINE_W-1:0] ic_data_i,
    output logic [LINE_W-1:0] ic_data_o,
    output logic              ic_ack_o,
    input  logic              dc_req_i,
    input  logic              dc_write_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_data_i,
    output logic [LINE_W-1:0] dc_data_o,
    output logic              dc_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o
);

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   pick_win;

    mem_arb_pick u_pick (
        .ic_req     (ic_req_i),
        .dc_req     (dc_req_i),
        .last_grant (last_grant),
        .win        (pick_win)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            owner        <= PORT_IC;
            last_grant   <= PORT_DC;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            ic_data_o    <= '0;
            dc_data_o    <= '0;
            ic_ack_o     <= 1'b0;
            dc_ack_o     <= 1'b0;
            grant_o      <= GNT_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_req_i || dc_req_i) begin
                        owner        <= pick_win;
                        grant_o      <= port_onehot(pick_win);
                        mem_enable_o <= 1'b1;
                        if (pick_win == PORT_DC) begin
                            mem_write_o <= dc_write_i;
                            mem_addr_o  <= dc_addr_i;
                            mem_data_o  <= dc_data_i;
                        end else begin
                            mem_write_o <= ic_write_i;
                            mem_addr_o  <= ic_addr_i;
                            mem_data_o  <= ic_data_i;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        grant_o      <= GNT_NONE;
                        // Writes complete without touching the owner's read-data register.
                        if (owner == PORT_DC) begin
                            dc_ack_o <= 1'b1;
                            if (!mem_write_o) dc_data_o <= mem_data_i;
                        end else begin
                            ic_ack_o <= 1'b1;
                            if (!mem_write_o) ic_data_o <= mem_data_i;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    ic_ack_o   <= 1'b0;
                    dc_ack_o   <= 1'b0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
